// File: rtl/airplane_control.sv
// Per-frame erase/move/redraw sequencer for a 4x4 plane sprite feeding the pixel datapath.
// Pass latency 36 cycles from tick; outputs are decoded from registered state, no backpressure.
module airplane_control #(
    parameter logic [8:0] X_POS        = 9'd20,
    parameter logic [7:0] Y_INIT       = 8'd56,
    parameter logic [7:0] Y_MIN        = 8'd0,
    parameter logic [7:0] Y_MAX        = 8'd116,
    parameter logic [7:0] STEP         = 8'd1,
    parameter int         FRAME_CYCLES = 833333,
    parameter logic [2:0] BG_COLOR     = 3'b000,
    parameter logic [2:0] PLANE_COLOR  = 3'b111
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       up,
    input  logic       down,
    output logic       ld_x,
    output logic       ld_y,
    output logic       ld_color,
    output logic [8:0] x_in,
    output logic [7:0] y_in,
    output logic [2:0] color_in,
    output logic       dp_enable,
    output logic       plot,
    output logic       busy,
    output logic [7:0] plane_y
);
    localparam int CW = $clog2(FRAME_CYCLES);
    localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_CYCLES - 1);

    typedef enum logic [2:0] {
        S_WAIT,
        S_LOAD_ERASE,
        S_ERASE,
        S_UPDATE,
        S_LOAD_DRAW,
        S_DRAW
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] frame_q, frame_d;
    logic          pending_q, pending_d;
    logic [3:0]    pass_q, pass_d;
    logic [7:0]    plane_y_q, plane_y_d;
    logic          tick;
    logic [8:0]    y_dec, y_inc;

    assign tick  = (frame_q == FRAME_LAST);
    assign y_dec = {1'b0, plane_y_q} - {1'b0, STEP};
    assign y_inc = {1'b0, plane_y_q} + {1'b0, STEP};

    always_comb begin
        state_d   = state_q;
        frame_d   = tick ? '0 : frame_q + 1'b1;
        pending_d = pending_q;
        pass_d    = pass_q;
        plane_y_d = plane_y_q;

        // A tick that arrives while a frame is already queued is simply absorbed.
        if (tick)
            pending_d = 1'b1;

        case (state_q)
            S_WAIT: begin
                if (tick || pending_q) begin
                    state_d   = S_LOAD_ERASE;
                    pending_d = 1'b0;
                end
            end
            S_LOAD_ERASE: begin
                state_d = S_ERASE;
                pass_d  = '0;
            end
            S_ERASE: begin
                pass_d = pass_q + 1'b1;
                if (pass_q == 4'd15)
                    state_d = S_UPDATE;
            end
            S_UPDATE: begin
                state_d = S_LOAD_DRAW;
                if (up && !down) begin
                    if (y_dec[8] || (y_dec < {1'b0, Y_MIN}))
                        plane_y_d = Y_MIN;
                    else
                        plane_y_d = y_dec[7:0];
                end else if (down && !up) begin
                    if (y_inc > {1'b0, Y_MAX})
                        plane_y_d = Y_MAX;
                    else
                        plane_y_d = y_inc[7:0];
                end
            end
            S_LOAD_DRAW: begin
                state_d = S_DRAW;
                pass_d  = '0;
            end
            S_DRAW: begin
                pass_d = pass_q + 1'b1;
                if (pass_q == 4'd15)
                    state_d = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_WAIT;
            frame_q   <= '0;
            pending_q <= 1'b0;
            pass_q    <= '0;
            plane_y_q <= Y_INIT;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            pending_q <= pending_d;
            pass_q    <= pass_d;
            plane_y_q <= plane_y_d;
        end
    end

    always_comb begin
        ld_x      = (state_q == S_LOAD_ERASE) || (state_q == S_LOAD_DRAW);
        ld_y      = ld_x;
        ld_color  = ld_x;
        dp_enable = (state_q == S_ERASE) || (state_q == S_DRAW);
        plot      = dp_enable;
        busy      = (state_q != S_WAIT);
        x_in      = X_POS;
        y_in      = plane_y_q;
        color_in  = ((state_q == S_LOAD_DRAW) || (state_q == S_DRAW)) ? PLANE_COLOR : BG_COLOR;
    end

    assign plane_y = plane_y_q;

endmodule

// File: tb/tb_airplane_control.sv
// Directed bench for airplane_control: table of key/Y vectors plus saturation and reset corners.
module tb_airplane_control;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       up, down;
    logic       ld_x, ld_y, ld_color, dp_enable, plot, busy;
    logic [8:0] x_in;
    logic [7:0] y_in, plane_y;
    logic [2:0] color_in;

    int n_checks = 0;
    int n_fail   = 0;

    airplane_control #(.FRAME_CYCLES(64)) dut (
        .clk(clk), .reset_n(reset_n), .up(up), .down(down),
        .ld_x(ld_x), .ld_y(ld_y), .ld_color(ld_color),
        .x_in(x_in), .y_in(y_in), .color_in(color_in),
        .dp_enable(dp_enable), .plot(plot), .busy(busy), .plane_y(plane_y)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       up;
        logic       down;
        logic [7:0] erase_y;
        logic [7:0] draw_y;
    } vec_t;

    function automatic logic [25:0] outs_now();
        return {ld_x, ld_y, ld_color, dp_enable, plot, busy, color_in, y_in, x_in};
    endfunction

    // Expected output bundle for cycle c of a pass (c=0 is LOAD_ERASE, c=35 back in WAIT).
    function automatic logic [25:0] outs_exp(int c, logic [7:0] ey, logic [7:0] dy);
        logic ld, en, bz;
        logic [2:0] col;
        logic [7:0] y;
        ld  = (c == 0) || (c == 18);
        en  = (c >= 1 && c <= 16) || (c >= 19 && c <= 34);
        bz  = (c <= 34);
        col = (c >= 18 && c <= 34) ? 3'b111 : 3'b000;
        y   = (c <= 17) ? ey : dy;
        return {ld, ld, ld, en, en, bz, col, y, 9'd20};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Waits (bounded) for a pass to start, then checks every cycle of it.
    task automatic run_pass(input logic [7:0] ey, input logic [7:0] dy, output int waited);
        waited = 0;
        do begin
            @(posedge clk); #1;
            waited++;
        end while (!busy && waited < 200);
        if (!busy) begin
            check("pass_start_timeout", 32'(busy), 32'd1);
            return;
        end
        check("pass_c0_outs", 32'(outs_now()), 32'(outs_exp(0, ey, dy)));
        check("pass_c0_plane_y", 32'(plane_y), 32'(ey));
        for (int c = 1; c <= 35; c++) begin
            @(posedge clk); #1;
            check($sformatf("pass_c%0d_outs", c), 32'(outs_now()), 32'(outs_exp(c, ey, dy)));
        end
        check("pass_end_plane_y", 32'(plane_y), 32'(dy));
    endtask

    vec_t vecs[7];
    int   waited;
    logic [7:0] y_model;

    initial begin
        vecs[0] = '{1'b0, 1'b0, 8'd56, 8'd56};
        vecs[1] = '{1'b1, 1'b0, 8'd56, 8'd55};
        vecs[2] = '{1'b1, 1'b0, 8'd55, 8'd54};
        vecs[3] = '{1'b1, 1'b0, 8'd54, 8'd53};
        vecs[4] = '{1'b1, 1'b1, 8'd53, 8'd53};
        vecs[5] = '{1'b0, 1'b1, 8'd53, 8'd54};
        vecs[6] = '{1'b0, 1'b0, 8'd54, 8'd54};

        up = 1'b0; down = 1'b0; reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", 32'(outs_now()), 32'({6'b0, 3'b000, 8'd56, 9'd20}));
        check("reset_plane_y", 32'(plane_y), 32'd56);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            up   = vecs[i].up;
            down = vecs[i].down;
            run_pass(vecs[i].erase_y, vecs[i].draw_y, waited);
            if (i == 0)
                check("first_tick_latency", 32'(waited), 32'd64);
            else
                check("frame_period", 32'(waited), 32'd29);
        end

        // Drive into the top boundary and hold there.
        y_model = 8'd54;
        up = 1'b1; down = 1'b0;
        for (int f = 0; f < 60; f++) begin
            run_pass(y_model, (y_model == 8'd0) ? 8'd0 : y_model - 8'd1, waited);
            if (y_model != 8'd0) y_model = y_model - 8'd1;
        end
        check("sat_min", 32'(plane_y), 32'd0);

        up = 1'b0; down = 1'b1;
        for (int f = 0; f < 120; f++) begin
            run_pass(y_model, (y_model == 8'd116) ? 8'd116 : y_model + 8'd1, waited);
            if (y_model != 8'd116) y_model = y_model + 8'd1;
        end
        check("sat_max", 32'(plane_y), 32'd116);
        down = 1'b0;

        // Reset during the fifth erase cycle.
        waited = 0;
        do begin
            @(posedge clk); #1;
            waited++;
        end while (!busy && waited < 200);
        check("rst_pass_started", 32'(busy), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("rst_pre_plot", 32'(plot), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_async_outs", 32'({plot, dp_enable, busy, ld_x}), 32'd0);
        check("rst_async_plane_y", 32'(plane_y), 32'd56);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        run_pass(8'd56, 8'd56, waited);
        check("rst_restart_latency", 32'(waited), 32'd64);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
